// File: rtl/float_mul_seq.sv
// Iterative IEEE-754 single-precision multiplier.
// A start pulse in idle latches the operands; a shift-add loop forms the 24x24 significand
// product one bit per cycle, then the product is normalised, rounded, packed and returned
// with a one-cycle done pulse. Latency is fixed at 26 edges after the accepting edge.
// Build option: define FLOAT_MUL_ROUND_NEAREST_EN for round-to-nearest-even; otherwise
// the mantissa is truncated (round toward zero) and no rounding logic is built.

module float_mul_seq #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MUL_STEPS = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            overflow,
    output logic            underflow
);

    localparam int unsigned CntW = $clog2(MUL_STEPS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StNorm,
        StPack,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic              sign_q, sign_d;
    logic [7:0]        ea_q, ea_d;
    logic [7:0]        eb_q, eb_d;
    logic [47:0]       mcand_q, mcand_d;
    logic [23:0]       mplier_q, mplier_d;
    logic [47:0]       prod_q, prod_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [22:0]       mant_q, mant_d;
    logic              inc_q, inc_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
    logic              guard_q, guard_d;
    logic              sticky_q, sticky_d;
`endif

    // Denormals are treated as zero, so their significand is forced to zero.
    logic [23:0] sig_a, sig_b;
    assign sig_a = (a[30:23] != 8'h00) ? {1'b1, a[22:0]} : 24'h0;
    assign sig_b = (b[30:23] != 8'h00) ? {1'b1, b[22:0]} : 24'h0;

    logic signed [9:0] exp_raw;
    logic signed [9:0] exp_rnd;
    logic [22:0]       mant_rnd;
    logic [XLEN-1:0]   pack_res;
    logic              pack_ovf;
    logic              pack_unf;
    logic              a_zero, b_zero, a_inf, b_inf;

    assign a_zero = (ea_q == 8'h00);
    assign b_zero = (eb_q == 8'h00);
    assign a_inf  = (ea_q == 8'hFF);
    assign b_inf  = (eb_q == 8'hFF);

    assign exp_raw = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'sd127
                   + $signed({9'b0, inc_q});

`ifdef FLOAT_MUL_ROUND_NEAREST_EN
    logic        round_up;
    logic [23:0] mant_sum;
    assign round_up = guard_q & (sticky_q | mant_q[0]);
    assign mant_sum = {1'b0, mant_q} + {23'b0, round_up};
    // A carry out leaves the low 23 bits at zero, so only the exponent needs bumping.
    assign mant_rnd = mant_sum[22:0];
    assign exp_rnd  = exp_raw + $signed({9'b0, mant_sum[23]});
`else
    assign mant_rnd = mant_q;
    assign exp_rnd  = exp_raw;
`endif

    // Result packing: special operands first, then exponent range saturation.
    always_comb begin
        pack_res = {sign_q, exp_rnd[7:0], mant_rnd};
        pack_ovf = 1'b0;
        pack_unf = 1'b0;
        if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            pack_res = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            pack_res = {sign_q, 8'hFF, 23'h0};
        end else if (a_zero || b_zero) begin
            pack_res = {sign_q, 31'h0};
        end else if (exp_rnd >= 10'sd255) begin
            pack_res = {sign_q, 8'hFF, 23'h0};
            pack_ovf = 1'b1;
        end else if (exp_rnd <= 10'sd0) begin
            pack_res = {sign_q, 31'h0};
            pack_unf = 1'b1;
        end
    end

    // Next-state and datapath update for each FSM phase.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        mant_d   = mant_q;
        inc_d    = inc_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
        guard_d  = guard_q;
        sticky_d = sticky_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StMul;
                    sign_d   = a[31] ^ b[31];
                    ea_d     = a[30:23];
                    eb_d     = b[30:23];
                    mcand_d  = {24'h0, sig_a};
                    mplier_d = sig_b;
                    prod_d   = 48'h0;
                    cnt_d    = '0;
                    inc_d    = 1'b0;
                end
            end
            StMul: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntW'(MUL_STEPS - 1)) begin
                    state_d = StNorm;
                end
            end
            StNorm: begin
                state_d = StPack;
                if (prod_q[47]) begin
                    mant_d   = prod_q[46:24];
                    inc_d    = 1'b1;
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
                    guard_d  = prod_q[23];
                    sticky_d = |prod_q[22:0];
`endif
                end else begin
                    mant_d   = prod_q[45:23];
                    inc_d    = 1'b0;
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
                    guard_d  = prod_q[22];
                    sticky_d = |prod_q[21:0];
`endif
                end
            end
            StPack: begin
                state_d  = StDone;
                result_d = pack_res;
                ovf_d    = pack_ovf;
                unf_d    = pack_unf;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            ea_q     <= 8'h0;
            eb_q     <= 8'h0;
            mcand_q  <= 48'h0;
            mplier_q <= 24'h0;
            prod_q   <= 48'h0;
            cnt_q    <= '0;
            mant_q   <= 23'h0;
            inc_q    <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            mant_q   <= mant_d;
            inc_q    <= inc_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
`endif
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_float_mul_seq.sv
// Self-checking bench for float_mul_seq: directed vector table, an abort-by-reset
// sequence, and random operands checked against an arithmetic reference model.

module tb_float_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    float_mul_seq #(
        .XLEN      (32),
        .MUL_STEPS (24)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        int          restart;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: real-number style product of the significands, normalised and rounded
    // with integer arithmetic on the exact 48-bit product.
    function automatic logic [33:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic            s;
        int              ex, ey, e, sh;
        longint unsigned px, py, p, mant;
        logic [31:0]     r;
        logic            ov, un;
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
        longint unsigned rem, half;
`endif
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        ov = 1'b0;
        un = 1'b0;
        if ((ex == 255 && ey == 0) || (ey == 255 && ex == 0)) begin
            r = 32'h7FC0_0000;
        end else if (ex == 255 || ey == 255) begin
            r = {s, 8'hFF, 23'h0};
        end else if (ex == 0 || ey == 0) begin
            r = {s, 31'h0};
        end else begin
            px = 64'(x[22:0]) + 64'h80_0000;
            py = 64'(y[22:0]) + 64'h80_0000;
            p  = px * py;
            sh = (p >= 64'h8000_0000_0000) ? 24 : 23;
            e  = ex + ey - 127 + (sh - 23);
            mant = (p >> sh) - 64'h80_0000;
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
            rem  = p - ((p >> sh) << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && mant[0])) mant = mant + 1;
            if (mant == 64'h80_0000) begin
                mant = 0;
                e    = e + 1;
            end
`endif
            if (e >= 255) begin
                r  = {s, 8'hFF, 23'h0};
                ov = 1'b1;
            end else if (e <= 0) begin
                r  = {s, 31'h0};
                un = 1'b1;
            end else begin
                r = {s, 8'(e), 23'(mant)};
            end
        end
        return {r, ov, un};
    endfunction

    function automatic logic [31:0] rand_op();
        int          k;
        logic [7:0]  e;
        logic [22:0] f;
        k = int'($urandom_range(0, 11));
        f = 23'($urandom);
        case (k)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(1, 20));
            3:       e = 8'($urandom_range(230, 254));
            4: begin
                e = 8'($urandom_range(110, 140));
                f = 23'h7F_FFFF;
            end
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), e, f};
    endfunction

    // One operation: start is driven at a falling edge, so the next rising edge is E0 and
    // negedge index n observes the state after edge E0+n-1.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input int restart_at,
                          output logic [31:0] r, output logic ro, output logic ru,
                          output int done_at, output int done_n, output int busy_n,
                          output logic [31:0] r_held);
        @(negedge clk);
        a       = ia;
        b       = ib;
        start   = 1'b1;
        done_at = -1;
        done_n  = 0;
        busy_n  = 0;
        r       = 32'h0;
        ro      = 1'b0;
        ru      = 1'b0;
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = n;
                    r       = result;
                    ro      = overflow;
                    ru      = underflow;
                end
            end
            if (n == 1) start = 1'b0;
            if (restart_at > 0 && n == restart_at) begin
                start = 1'b1;
                a     = ~ia;
                b     = ~ib;
            end
            if (restart_at > 0 && n == restart_at + 1) start = 1'b0;
        end
        r_held = result;
    endtask

    initial begin
        logic [31:0] r, r_held;
        logic        ro, ru;
        int          done_at, done_n, busy_n, dn;
        logic [33:0] exp_v;
        logic [31:0] ra, rb;

        vecs[0] = '{32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 0};
        vecs[1] = '{32'hC040_0000, 32'h3F00_0000, 32'hBFC0_0000, 1'b0, 1'b0, 5};
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
        vecs[2] = '{32'h3FC0_0001, 32'h3FC0_0001, 32'h4010_0002, 1'b0, 1'b0, 0};
`else
        vecs[2] = '{32'h3FC0_0001, 32'h3FC0_0001, 32'h4010_0001, 1'b0, 1'b0, 0};
`endif
        vecs[3] = '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1, 1'b0, 0};
        vecs[4] = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b1, 0};
        vecs[5] = '{32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 1'b0, 1'b0, 0};
        vecs[6] = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0, 0};
        vecs[7] = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0, 1'b0, 0};
        vecs[8] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 3};

        start = 1'b0;
        a     = 32'h0;
        b     = 32'h0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset done", {31'h0, done}, 32'h0);
        check("reset result", result, 32'h0);
        check("reset overflow", {31'h0, overflow}, 32'h0);
        check("reset underflow", {31'h0, underflow}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].restart, r, ro, ru, done_at, done_n, busy_n,
                   r_held);
            check($sformatf("vec%0d result", i), r, vecs[i].res);
            check($sformatf("vec%0d overflow", i), {31'h0, ro}, {31'h0, vecs[i].ovf});
            check($sformatf("vec%0d underflow", i), {31'h0, ru}, {31'h0, vecs[i].unf});
            check($sformatf("vec%0d done cycle", i), done_at, 27);
            check($sformatf("vec%0d done count", i), done_n, 1);
            check($sformatf("vec%0d busy cycles", i), busy_n, 27);
            check($sformatf("vec%0d result held", i), r_held, vecs[i].res);
        end

        // Abort mid-multiply: reset clears outputs at once and no done follows.
        run_op(32'h3FC0_0000, 32'h4000_0000, 0, r, ro, ru, done_at, done_n, busy_n, r_held);
        check("pre-abort result", r, 32'h4040_0000);
        @(negedge clk);
        a     = 32'h4040_0000;
        b     = 32'h4040_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("abort busy before reset", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'h0, busy}, 32'h0);
        check("abort done", {31'h0, done}, 32'h0);
        check("abort result", result, 32'h0);
        check("abort overflow", {31'h0, overflow}, 32'h0);
        check("abort underflow", {31'h0, underflow}, 32'h0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort no done", dn, 0);
        check("abort idle busy", {31'h0, busy}, 32'h0);
        run_op(32'h3FC0_0000, 32'h4000_0000, 0, r, ro, ru, done_at, done_n, busy_n, r_held);
        check("post-abort result", r, 32'h4040_0000);
        check("post-abort done cycle", done_at, 27);
        check("post-abort busy cycles", busy_n, 27);

        for (int i = 0; i < 150; i++) begin
            ra    = rand_op();
            rb    = rand_op();
            exp_v = ref_mul(ra, rb);
            run_op(ra, rb, 0, r, ro, ru, done_at, done_n, busy_n, r_held);
            check($sformatf("rand%0d %h*%h result", i, ra, rb), r, exp_v[33:2]);
            check($sformatf("rand%0d overflow", i), {31'h0, ro}, {31'h0, exp_v[1]});
            check($sformatf("rand%0d underflow", i), {31'h0, ru}, {31'h0, exp_v[0]});
            check($sformatf("rand%0d done cycle", i), done_at, 27);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
